// File: rtl/shim_spi_cfg_pkg.sv
// Shared widths and default filter parameters for the AXI-to-SPI configuration synchronizer.
package shim_spi_cfg_pkg;

    localparam int unsigned THRESH_W  = 15;
    localparam int unsigned WINDOW_W  = 32;
    localparam int unsigned CS_TIME_W = 8;
    localparam int unsigned SKIP_W    = 16;

    localparam int unsigned DEFAULT_DEPTH        = 3;
    localparam int unsigned DEFAULT_STABLE_COUNT = 2;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/shim_stable_sync.sv
// Multi-flop synchronizer followed by a stability filter; stable asserts once the synchronized
// word has held for STABLE_COUNT consecutive edges.
module shim_stable_sync
    import shim_spi_cfg_pkg::*;
#(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic             spi_clk,
    input  logic             spi_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             stable
);

    localparam int unsigned CW = cnt_width(STABLE_COUNT);

    logic [WIDTH-1:0] chain_q [DEPTH];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Count on the values about to be registered so the filter adds no extra edge of latency.
    always_comb begin
        cnt_d = cnt_q;
        if (chain_q[DEPTH-2] != chain_q[DEPTH-1]) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STABLE_COUNT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                chain_q[i] <= '0;
            end
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            chain_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[DEPTH-1];
            cnt_q  <= cnt_d;
        end
    end

    assign dout   = chain_q[DEPTH-1];
    assign stable = (dout == prev_q) && (cnt_q == CW'(STABLE_COUNT));

endmodule

// File: rtl/shim_spi_cfg_sync.sv
// Moves static SPI configuration and the SPI enable into the SPI clock domain, freezing the
// configuration while enabled and granting enable only once the configuration has settled.
module shim_spi_cfg_sync
    import shim_spi_cfg_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic                 spi_clk,
    input  logic                 spi_rst,
    input  logic                 spi_en,
    input  logic [THRESH_W-1:0]  integ_thresh_avg,
    input  logic [WINDOW_W-1:0]  integ_window,
    input  logic                 integ_en,
    input  logic [CS_TIME_W-1:0] dac_n_cs_high_time,
    input  logic [CS_TIME_W-1:0] adc_n_cs_high_time,
    input  logic [SKIP_W-1:0]    boot_test_skip,
    output logic                 spi_en_stable,
    output logic [THRESH_W-1:0]  integ_thresh_avg_stable,
    output logic [WINDOW_W-1:0]  integ_window_stable,
    output logic                 integ_en_stable,
    output logic [CS_TIME_W-1:0] dac_n_cs_high_time_stable,
    output logic [CS_TIME_W-1:0] adc_n_cs_high_time_stable,
    output logic [SKIP_W-1:0]    boot_test_skip_stable,
    output logic                 cfg_ready
);

    logic                 en_s, en_st;
    logic [THRESH_W-1:0]  thresh_s;
    logic [WINDOW_W-1:0]  window_s;
    logic                 integ_en_s;
    logic [CS_TIME_W-1:0] dac_s, adc_s;
    logic [SKIP_W-1:0]    skip_s;
    logic [5:0]           cfg_st;

    shim_stable_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_en_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(spi_en), .dout(en_s), .stable(en_st)
    );
    shim_stable_sync #(.WIDTH(THRESH_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_thresh_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(integ_thresh_avg), .dout(thresh_s),
        .stable(cfg_st[0])
    );
    shim_stable_sync #(.WIDTH(WINDOW_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_window_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(integ_window), .dout(window_s),
        .stable(cfg_st[1])
    );
    shim_stable_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_integ_en_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(integ_en), .dout(integ_en_s),
        .stable(cfg_st[2])
    );
    shim_stable_sync #(.WIDTH(CS_TIME_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_dac_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(dac_n_cs_high_time), .dout(dac_s),
        .stable(cfg_st[3])
    );
    shim_stable_sync #(.WIDTH(CS_TIME_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_adc_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(adc_n_cs_high_time), .dout(adc_s),
        .stable(cfg_st[4])
    );
    shim_stable_sync #(.WIDTH(SKIP_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_skip_sync (
        .spi_clk(spi_clk), .spi_rst(spi_rst), .din(boot_test_skip), .dout(skip_s),
        .stable(cfg_st[5])
    );

    // The load gate uses the pre-edge enable, so a field settling on the enabling edge still loads.
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            spi_en_stable             <= 1'b0;
            cfg_ready                 <= 1'b0;
            integ_thresh_avg_stable   <= '0;
            integ_window_stable       <= '0;
            integ_en_stable           <= 1'b0;
            dac_n_cs_high_time_stable <= '0;
            adc_n_cs_high_time_stable <= '0;
            boot_test_skip_stable     <= '0;
        end else begin
            cfg_ready <= &cfg_st;
            if (en_st && !en_s) begin
                spi_en_stable <= 1'b0;
            end else if (en_st && en_s && cfg_ready) begin
                spi_en_stable <= 1'b1;
            end
            if (!spi_en_stable) begin
                if (cfg_st[0]) integ_thresh_avg_stable   <= thresh_s;
                if (cfg_st[1]) integ_window_stable       <= window_s;
                if (cfg_st[2]) integ_en_stable           <= integ_en_s;
                if (cfg_st[3]) dac_n_cs_high_time_stable <= dac_s;
                if (cfg_st[4]) adc_n_cs_high_time_stable <= adc_s;
                if (cfg_st[5]) boot_test_skip_stable     <= skip_s;
            end
        end
    end

endmodule
